// File: rtl/conv_seq_if.sv
// rtl/conv_seq_if.sv - datapath-side bus between conv_seq and the image/kernel/MAC/result blocks
interface conv_seq_if #(
  parameter int IMG_AW  = 16,
  parameter int KERN_AW = 6,
  parameter int RES_AW  = 16
);
  logic [IMG_AW-1:0]  img_addr;
  logic               img_ready;
  logic [KERN_AW-1:0] kern_addr;
  logic               mac_valid;
  logic               mac_first;
  logic               mac_last;
  logic               mac_ovf;
  logic               res_wr_en;
  logic [RES_AW-1:0]  res_addr;
  logic               pool_first;

  modport master (
    output img_addr, kern_addr, mac_valid, mac_first, mac_last,
    output res_wr_en, res_addr, pool_first,
    input  img_ready, mac_ovf
  );

  modport slave (
    input  img_addr, kern_addr, mac_valid, mac_first, mac_last,
    input  res_wr_en, res_addr, pool_first,
    output img_ready, mac_ovf
  );
endinterface

// File: rtl/conv_seq.sv
// rtl/conv_seq.sv - convolution address/strobe sequencer; optional 2:1 max-pool pairing under CONV_SEQ_MAXPOOL_EN
module conv_seq #(
  parameter int IMG_AW   = 16,
  parameter int KERN_AW  = 6,
  parameter int RES_AW   = 16,
  parameter int PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             soft_reset,
  input  logic [2:0]       kern_cols,
  input  logic [2:0]       kerns,
  input  logic [7:0]       stride,
  input  logic [7:0]       result_cols,
  input  logic             kern_addr_mode,
  input  logic             en_max_pool,
  conv_seq_if.master       dp,
  output logic             busy,
  output logic             done,
  output logic             accum_ovrflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Pipe pattern where only the final pending write remains, at the output stage
  localparam logic [PIPE_LAT-1:0] PIPE_TAIL = PIPE_LAT'(1) << (PIPE_LAT - 1);

  state_t              state;
  state_t              state_nxt;
  logic                start_q;
  logic [2:0]          k_cnt;
  logic [2:0]          t_cnt;
  logic [7:0]          r_cnt;
  logic [IMG_AW-1:0]   base;
  logic [RES_AW-1:0]   res_addr_q;
  logic [PIPE_LAT-1:0] wr_pipe;
  logic                accum_q;

  logic start_rise;
  logic accept;
  logic issue;
  logic last_t;
  logic last_r;
  logic last_k;
  logic final_tap;
  logic in_run;

  assign start_rise = start & ~start_q;
  assign accept     = start_rise & ~soft_reset & ((state == S_IDLE) || (state == S_DONE));
  assign in_run     = (state == S_RUN);
  assign issue      = in_run & dp.img_ready;
  assign last_t     = (t_cnt == kern_cols);
  assign last_r     = (r_cnt == result_cols - 8'd1);
  assign last_k     = (k_cnt == kerns);
  assign final_tap  = last_t & last_r & last_k;

  // Start level history for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; a zero-length job goes straight to DONE
  always_comb begin
    state_nxt = state;
    if (soft_reset) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) state_nxt = (result_cols != 8'd0) ? S_RUN : S_DONE;
        end
        S_RUN: begin
          if (issue && final_tap) state_nxt = S_DRAIN;
        end
        S_DRAIN: begin
          if (wr_pipe == PIPE_TAIL) state_nxt = S_DONE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Loop counters kernel/result/tap plus the running image base; all hold while img_ready is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_cnt <= '0;
      r_cnt <= '0;
      t_cnt <= '0;
      base  <= '0;
    end else if (soft_reset || accept) begin
      k_cnt <= '0;
      r_cnt <= '0;
      t_cnt <= '0;
      base  <= '0;
    end else if (issue) begin
      if (!last_t) begin
        t_cnt <= t_cnt + 3'd1;
      end else begin
        t_cnt <= '0;
        if (last_r) begin
          r_cnt <= '0;
          base  <= '0;
          k_cnt <= k_cnt + 3'd1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
          base  <= base + IMG_AW'(stride);
        end
      end
    end
  end

`ifdef CONV_SEQ_MAXPOOL_EN
  logic [PIPE_LAT-1:0] pf_pipe;
  logic                pf_in;

  // Even result with a partner behind it in the same kernel opens a pool pair
  assign pf_in = en_max_pool & ~r_cnt[0] & ~last_r;

  // Write-delay line matching the MAC latency, carrying the pool-first tag alongside
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_pipe <= '0;
      pf_pipe <= '0;
    end else if (soft_reset) begin
      wr_pipe <= '0;
      pf_pipe <= '0;
    end else begin
      wr_pipe[0] <= issue & last_t;
      pf_pipe[0] <= issue & last_t & pf_in;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wr_pipe[i] <= wr_pipe[i-1];
        pf_pipe[i] <= pf_pipe[i-1];
      end
    end
  end

  assign dp.res_wr_en  = wr_pipe[PIPE_LAT-1] & ~pf_pipe[PIPE_LAT-1];
  assign dp.pool_first = wr_pipe[PIPE_LAT-1] &  pf_pipe[PIPE_LAT-1];
`else
  logic unused_pool;
  assign unused_pool = en_max_pool;

  // Write-delay line matching the MAC latency; advances every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_pipe <= '0;
    end else if (soft_reset) begin
      wr_pipe <= '0;
    end else begin
      wr_pipe[0] <= issue & last_t;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wr_pipe[i] <= wr_pipe[i-1];
      end
    end
  end

  assign dp.res_wr_en  = wr_pipe[PIPE_LAT-1];
  assign dp.pool_first = 1'b0;
`endif

  // Result address advances after each write, contiguous across kernels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_addr_q <= '0;
    end else if (soft_reset || accept) begin
      res_addr_q <= '0;
    end else if (dp.res_wr_en) begin
      res_addr_q <= res_addr_q + RES_AW'(1);
    end
  end

  // Sticky overflow over the active part of a job
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accum_q <= 1'b0;
    end else if (soft_reset || accept) begin
      accum_q <= 1'b0;
    end else if (in_run || (state == S_DRAIN)) begin
      accum_q <= accum_q | dp.mac_ovf;
    end
  end

  assign dp.img_addr   = in_run ? (base + IMG_AW'(t_cnt)) : '0;
  assign dp.kern_addr  = in_run ? (kern_addr_mode ? KERN_AW'({k_cnt, t_cnt}) : KERN_AW'(t_cnt)) : '0;
  assign dp.mac_valid  = issue;
  assign dp.mac_first  = issue & (t_cnt == 3'd0);
  assign dp.mac_last   = issue & last_t;
  assign dp.res_addr   = res_addr_q;
  assign busy          = in_run || (state == S_DRAIN);
  assign done          = (state == S_DONE);
  assign accum_ovrflow = accum_q;

endmodule

// File: tb/tb_conv_seq.sv
// tb/tb_conv_seq.sv - directed self-checking bench for conv_seq
module tb_conv_seq;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       soft_reset;
  logic [2:0] kern_cols;
  logic [2:0] kerns;
  logic [7:0] stride;
  logic [7:0] result_cols;
  logic       kern_addr_mode;
  logic       en_max_pool;
  logic       busy;
  logic       done;
  logic       accum_ovrflow;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_rel;
  int acc0;
  int busy1;

  int got_img[$], got_kern[$], got_fl[$], got_wr[$], got_wr_cyc[$], got_last_cyc[$], got_pf[$];
  int exp_img[$], exp_kern[$], exp_fl[$], exp_wr[$], exp_pf[$];

  conv_seq_if #(.IMG_AW(16), .KERN_AW(6), .RES_AW(16)) dp_if ();

  conv_seq #(.IMG_AW(16), .KERN_AW(6), .RES_AW(16), .PIPE_LAT(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .soft_reset    (soft_reset),
    .kern_cols     (kern_cols),
    .kerns         (kerns),
    .stride        (stride),
    .result_cols   (result_cols),
    .kern_addr_mode(kern_addr_mode),
    .en_max_pool   (en_max_pool),
    .dp            (dp_if.master),
    .busy          (busy),
    .done          (done),
    .accum_ovrflow (accum_ovrflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dp_if.mac_valid) begin
      got_img.push_back(int'(dp_if.img_addr));
      got_kern.push_back(int'(dp_if.kern_addr));
      got_fl.push_back(int'({dp_if.mac_first, dp_if.mac_last}));
      if (dp_if.mac_last) got_last_cyc.push_back(cyc);
    end
    if (dp_if.pool_first) got_pf.push_back(got_wr.size());
    if (dp_if.res_wr_en) begin
      got_wr.push_back(int'(dp_if.res_addr));
      got_wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic verify(input string tag, input bit lat_chk);
    check({tag, "_ntaps"}, got_img.size(), exp_img.size());
    for (int i = 0; i < exp_img.size() && i < got_img.size(); i++) begin
      check($sformatf("%s_img%0d", tag, i), got_img[i], exp_img[i]);
      check($sformatf("%s_kern%0d", tag, i), got_kern[i], exp_kern[i]);
      check($sformatf("%s_firstlast%0d", tag, i), got_fl[i], exp_fl[i]);
    end
    check({tag, "_nwr"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check($sformatf("%s_res_addr%0d", tag, i), got_wr[i], exp_wr[i]);
    check({tag, "_npool"}, got_pf.size(), exp_pf.size());
    for (int i = 0; i < exp_pf.size() && i < got_pf.size(); i++)
      check($sformatf("%s_pool_pos%0d", tag, i), got_pf[i], exp_pf[i]);
    if (lat_chk) begin
      for (int i = 0; i < got_wr_cyc.size() && i < got_last_cyc.size(); i++)
        check($sformatf("%s_wr_lat%0d", tag, i), got_wr_cyc[i] - got_last_cyc[i], 3);
    end
  endtask

  // n counts cycles from the first RUN cycle; start is sampled at the edge opening n=0
  task automatic run_job(input int kc, input int kk, input int st, input int rc, input int mode,
                         input int pool, input int lo_at, input int lo_len, input int retog,
                         input int ovf_at, input int sr_at, input int rst_at);
    bit abort;
    abort = (sr_at >= 0) || (rst_at >= 0);
    kern_cols      = 3'(kc);
    kerns          = 3'(kk);
    stride         = 8'(st);
    result_cols    = 8'(rc);
    kern_addr_mode = 1'(mode);
    en_max_pool    = 1'(pool);
    @(posedge clk); #1;
    start = 1'b0;
    got_img.delete(); got_kern.delete(); got_fl.delete(); got_wr.delete();
    got_wr_cyc.delete(); got_last_cyc.delete(); got_pf.delete();
    @(posedge clk); #1;
    start = 1'b1;
    done_rel = -1;
    acc0 = -1;
    busy1 = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      dp_if.img_ready = !(n >= lo_at && n < lo_at + lo_len);
      dp_if.mac_ovf   = (n == ovf_at);
      soft_reset      = (n == sr_at);
      reset           = !(n == rst_at);
      if (retog != 0 && n >= 3 && n < 5) start = 1'b0;
      else if (abort && (n >= sr_at && sr_at >= 0 || n >= rst_at && rst_at >= 0)) start = 1'b0;
      else start = 1'b1;
      @(negedge clk);
      if (n == 0) acc0 = int'(accum_ovrflow);
      if (n == 1) busy1 = int'(busy);
      if (done && done_rel < 0) done_rel = n;
      if (!abort && done_rel >= 0) break;
      if (abort && n == 14) break;
    end
    #1;
    dp_if.img_ready = 1'b1;
    dp_if.mac_ovf   = 1'b0;
    soft_reset      = 1'b0;
    reset           = 1'b1;
  endtask

  task automatic expect_t1();
    exp_img  = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
    exp_kern = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    exp_fl   = '{2, 0, 1, 2, 0, 1, 2, 0, 1};
    exp_wr   = '{0, 1, 2};
    exp_pf.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; soft_reset = 1'b0;
    kern_cols = '0; kerns = '0; stride = '0; result_cols = '0;
    kern_addr_mode = 1'b0; en_max_pool = 1'b0;
    dp_if.img_ready = 1'b1; dp_if.mac_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", {dp_if.img_addr, dp_if.res_addr}, 32'd0);
    check("rst_flags", 32'({dp_if.kern_addr, dp_if.mac_valid, dp_if.mac_first, dp_if.mac_last,
                            dp_if.res_wr_en, dp_if.pool_first, busy, done, accum_ovrflow}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // single kernel, three taps, three results
    expect_t1();
    run_job(2, 0, 1, 3, 0, 0, -1, 0, 0, -1, -1, -1);
    verify("t1", 1'b1);
    check("t1_done_rel", done_rel, 12);
    check("t1_busy_run", busy1, 1);
    check("t1_busy_done", 32'({busy, done}), 32'd1);

    // two kernels, single tap, kernel base addressing, overflow pulse
    exp_img  = '{0, 4, 0, 4};
    exp_kern = '{0, 0, 8, 8};
    exp_fl   = '{3, 3, 3, 3};
    exp_wr   = '{0, 1, 2, 3};
    exp_pf.delete();
    run_job(0, 1, 4, 2, 1, 0, -1, 0, 0, 2, -1, -1);
    verify("t2", 1'b1);
    check("t2_done_rel", done_rel, 7);
    check("t2_acc_start", acc0, 0);
    check("t2_acc_done", 32'(accum_ovrflow), 32'd1);
    repeat (3) @(negedge clk);
    check("t2_acc_held", 32'({accum_ovrflow, done}), 32'd3);

    // image stall mid-result
    expect_t1();
    run_job(2, 0, 1, 3, 0, 0, 4, 5, 0, -1, -1, -1);
    verify("t3", 1'b1);
    check("t3_done_rel", done_rel, 17);
    check("t3_acc_cleared", acc0, 0);

    // second start edge during RUN is ignored
    expect_t1();
    run_job(2, 0, 1, 3, 0, 0, -1, 0, 1, -1, -1, -1);
    verify("t4", 1'b1);
    check("t4_done_rel", done_rel, 12);

    // zero-length job
    exp_img.delete(); exp_kern.delete(); exp_fl.delete(); exp_wr.delete(); exp_pf.delete();
    run_job(2, 0, 1, 0, 0, 0, -1, 0, 0, -1, -1, -1);
    verify("t5", 1'b0);
    check("t5_done_rel", done_rel, 0);
    check("t5_busy_done", 32'({busy, done}), 32'd1);

    // soft reset mid-RUN
    exp_img  = '{0, 1, 2, 1, 2};
    exp_kern = '{0, 1, 2, 0, 1};
    exp_fl   = '{2, 0, 1, 2, 0};
    exp_wr.delete(); exp_pf.delete();
    run_job(2, 0, 1, 3, 0, 0, -1, 0, 0, -1, 4, -1);
    verify("t6", 1'b0);
    check("t6_done_rel", done_rel, -1);
    check("t6_idle", 32'({busy, done, dp_if.img_addr, dp_if.res_addr}), 32'd0);

    // async reset mid-RUN
    exp_img  = '{0, 1, 2, 1};
    exp_kern = '{0, 1, 2, 0};
    exp_fl   = '{2, 0, 1, 2};
    exp_wr.delete(); exp_pf.delete();
    run_job(2, 0, 1, 3, 0, 0, -1, 0, 0, -1, -1, 4);
    verify("t7", 1'b0);
    check("t7_done_rel", done_rel, -1);
    check("t7_idle", 32'({busy, done, dp_if.res_addr}), 32'd0);

    // clean job after aborts
    expect_t1();
    run_job(2, 0, 1, 3, 0, 0, -1, 0, 0, -1, -1, -1);
    verify("t8", 1'b1);
    check("t8_done_rel", done_rel, 12);

    // max-pool request with five results
    exp_img  = '{0, 1, 2, 3, 4};
    exp_kern = '{0, 0, 0, 0, 0};
    exp_fl   = '{3, 3, 3, 3, 3};
`ifdef CONV_SEQ_MAXPOOL_EN
    exp_wr   = '{0, 1, 2};
    exp_pf   = '{0, 1};
    run_job(0, 0, 1, 5, 0, 1, -1, 0, 0, -1, -1, -1);
    verify("t9", 1'b0);
`else
    exp_wr   = '{0, 1, 2, 3, 4};
    exp_pf.delete();
    run_job(0, 0, 1, 5, 0, 1, -1, 0, 0, -1, -1, -1);
    verify("t9", 1'b1);
`endif
    check("t9_done_rel", done_rel, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_seq.md
# conv_seq

Sequencer for the convolution engine. It turns the configuration fields and start/soft_reset bits from the control/status register file into a cycle-by-cycle stream of image addresses, kernel addresses and MAC control strobes. It issues result-buffer writes after the MAC pipeline latency and returns `done` and a sticky overflow flag to the status register. It sits between the register file and the image buffer, kernel store, MAC/shift datapath and result buffer.

## Interface
- `IMG_AW`, 16: image buffer address width.
- `KERN_AW`, 6: kernel store address width (must be ≥ 6).
- `RES_AW`, 16: result buffer address width.
- `PIPE_LAT`, 3: cycles from a `mac_last` issue to the matching result being valid at the datapath output (≥ 1).
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: level from the control register; the block acts on its rising edge only.
- `soft_reset` in 1: synchronous abort and clear while high.
- `kern_cols` in 3: taps per kernel minus 1 (1..8 taps).
- `kerns` in 3: kernel count minus 1 (1..8 kernels).
- `stride` in 8: image address step between successive results.
- `result_cols` in 8: results per kernel; 0 means no work.
- `kern_addr_mode` in 1: 0 = all kernels use tap addresses 0..7; 1 = kernel k uses base k*8.
- `en_max_pool` in 1: enables 2:1 max-pool write pairing.
- `img_ready` in 1: image buffer can accept a read this cycle.
- `mac_ovf` in 1: per-cycle accumulator overflow from the datapath.
- `img_addr` out IMG_AW: image read address.
- `kern_addr` out KERN_AW: kernel read address.
- `mac_valid` out 1: tap issued this cycle.
- `mac_first` out 1: first tap of a result; the accumulator loads instead of adding.
- `mac_last` out 1: last tap of a result.
- `res_wr_en` out 1: result buffer write strobe.
- `res_addr` out RES_AW: result write address.
- `pool_first` out 1: marks the first element of a max-pool pair; the datapath latches it and does not write.
- `busy` out 1: a job is in progress.
- `done` out 1: the job is complete (sticky).
- `accum_ovrflow` out 1: sticky OR of `mac_ovf` over the job.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset and `soft_reset` both go to IDLE.
- IDLE/DONE → RUN on a rising edge of `start` when `result_cols != 0`. Entering RUN clears `done`, `accum_ovrflow`, all counters and `res_addr`.
- If `result_cols == 0`, a `start` edge goes directly to DONE and sets `done` on the next cycle. No strobes are issued.
- A `start` edge seen in RUN or DRAIN is ignored.
- Loop order, outermost first: kernel k (0..kerns), result r (0..result_cols-1), tap t (0..kern_cols).
- In RUN, a tap is issued when `img_ready` is 1. If `img_ready` is 0, `mac_valid` is 0 and every counter holds.
- `img_addr` = r*stride + t, generated with a running base that adds `stride` per result. The base resets to 0 at each new kernel. It wraps modulo 2^IMG_AW.
- `kern_addr` = t + (kern_addr_mode ? k*8 : 0).
- `mac_first` is asserted with t == 0 and `mac_last` with t == kern_cols. When kern_cols == 0, both are asserted on the same tap.
- RUN → DRAIN on the final tap (k == kerns, r == last, t == kern_cols). DRAIN → DONE once the last write has been issued.
- `res_wr_en` fires exactly PIPE_LAT cycles after each `mac_last`. This uses a PIPE_LAT-deep shift register that advances every cycle regardless of `img_ready`.
- `res_addr` increments after every write. It is contiguous across kernels and wraps modulo 2^RES_AW.
- `accum_ovrflow` ORs in `mac_ovf` during RUN and DRAIN, and holds in DONE.
- `soft_reset` high: next cycle in IDLE, all outputs at reset values, the write shift register flushed, `done` cleared. A `start` edge coinciding with `soft_reset` is ignored.

## Timing
- Reset values: every output is 0, including `done`, `busy` and `accum_ovrflow`.
- The first `mac_valid` occurs 1 cycle after the cycle in which the `start` rise is sampled.
- The block issues one tap per cycle at full rate.
- `busy` = 1 in RUN and DRAIN only.
- `done` rises in the cycle after the last `res_wr_en` and stays high until the next accepted start or `soft_reset`.
- With all `img_ready` = 1, total job length is (kerns+1)*result_cols*(kern_cols+1) issue cycles + PIPE_LAT.
- Configuration inputs are sampled live. Software must not change them in RUN or DRAIN; the result is undefined if it does.
- Asserting `reset` mid-job clears immediately and asynchronously. No partial writes occur after the reset edge.

## Configuration
- `CONV_SEQ_MAXPOOL_EN` defined:
  - When `en_max_pool` = 1, results pair as (0,1), (2,3), … within each kernel.
  - For the first of a pair, `pool_first` = 1 and `res_wr_en` = 0.
  - For the second, `res_wr_en` = 1 and `res_addr` advances by 1.
  - An odd trailing result is written alone with `pool_first` = 0.
  - Pairing restarts at each kernel.
- `CONV_SEQ_MAXPOOL_EN` not defined: `en_max_pool` is ignored, `pool_first` is tied to 0, and every result is written.

## Test plan
- kerns=0, kern_cols=2, result_cols=3, stride=1, `img_ready`=1 → `img_addr` 0,1,2,1,2,3,2,3,4; 3 writes at `res_addr` 0..2, each PIPE_LAT after `mac_last`; `done` 13 cycles after start.
- kerns=1, kern_cols=0, stride=4, result_cols=2, kern_addr_mode=1 → `img_addr` 0,4,0,4; `kern_addr` 0,0,8,8; `mac_first` = `mac_last` on every tap; `res_addr` 0..3.
- Same job with `img_ready` low for 5 cycles mid-result → counters freeze, no `mac_valid`, outputs identical apart from the delay.
- result_cols=0 → `done` next cycle, no strobes. A second `start` edge during RUN → ignored.
- `soft_reset` pulse, or `reset` low, mid-RUN → IDLE, no further `res_wr_en`, `done`=0; a new start then runs cleanly. A `mac_ovf` pulse in RUN → `accum_ovrflow` held 1 until the next start.
- With `CONV_SEQ_MAXPOOL_EN`, en_max_pool=1, result_cols=5, kerns=0 → 3 writes at `res_addr` 0,1,2; `pool_first` on results 0 and 2.
